// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state encoding and sizing constants for alu_adder_sequencer.
package alu_seq_pkg;

    localparam int unsigned WIDTH_DEF = 6;
    localparam int unsigned MUL_STEPS = 6;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_NEG = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StMul  = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/alu_adder_sequencer_adder.sv
// 6-bit ripple-carry adder/subtractor: sel=1 computes x - y as x + ~y + 1.
module _6bit_ripple_adder (
    input  logic [5:0] x,
    input  logic [5:0] y,
    input  logic       sel,
    output logic [5:0] sum,
    output logic       c_out,
    output logic       ovf
);

    logic [6:0] c;
    logic [5:0] yy;

    assign yy   = y ^ {6{sel}};
    assign c[0] = sel;

    for (genvar i = 0; i < 6; i++) begin : g_bit
        assign sum[i]   = x[i] ^ yy[i] ^ c[i];
        assign c[i+1]   = (x[i] & yy[i]) | (c[i] & (x[i] ^ yy[i]));
    end

    assign c_out = c[6];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf   = c[6] ^ c[5];

endmodule

// File: rtl/alu_adder_sequencer.sv
// ADD/SUB/NEG/MUL sequencer sharing one 6-bit ripple adder; start/busy/done handshake.
// Optional sticky overflow flag enabled by defining ALU_SEQ_STICKY_OVF_EN.
module alu_adder_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               ovf,
    output logic               carry
`ifdef ALU_SEQ_STICKY_OVF_EN
    ,
    input  logic               ovf_clr,
    output logic               ovf_sticky
`endif
);

    if (WIDTH != WIDTH_DEF) begin : g_width_check
        $error("alu_adder_sequencer: WIDTH must equal the adder width (6)");
    end

    state_e             state_q, state_d;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH:0]   p_q, p_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               mul_last;

    logic [WIDTH-1:0]   add_x, add_y, add_sum;
    logic               add_sel, add_cout, add_ovf;

    _6bit_ripple_adder u_adder (
        .x     (add_x),
        .y     (add_y),
        .sel   (add_sel),
        .sum   (add_sum),
        .c_out (add_cout),
        .ovf   (add_ovf)
    );

    assign mul_last = (cnt_q == CNT_W'(MUL_STEPS - 1));

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sel = 1'b0;
        unique case (state_q)
            StExec: begin
                case (op_q)
                    OP_ADD: begin
                        add_x = a_q;
                        add_y = b_q;
                    end
                    OP_SUB: begin
                        add_x   = a_q;
                        add_y   = b_q;
                        add_sel = 1'b1;
                    end
                    OP_NEG: begin
                        add_y   = b_q;
                        add_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            StMul: begin
                add_x = p_q[2*WIDTH-1:WIDTH];
                add_y = a_q;
            end
            default: ;
        endcase
    end

    // One shift-add step: add multiplicand into the upper half when the LSB is set.
    always_comb begin
        if (p_q[0]) begin
            p_next = {add_cout, add_sum, p_q[WIDTH-1:0]} >> 1;
        end else begin
            p_next = p_q >> 1;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (op_e'(op) == OP_MUL) ? StMul : StExec;
                end else begin
                    state_d = StIdle;
                end
            end
            StExec:  state_d = StDone;
            StMul:   state_d = mul_last ? StDone : StMul;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            carry   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op_e'(op);
                p_q   <= {{(WIDTH + 1){1'b0}}, b};
                cnt_q <= '0;
            end
            if (state_q == StExec) begin
                result <= {{WIDTH{1'b0}}, add_sum};
                ovf    <= add_ovf;
                carry  <= add_cout;
            end
            if (state_q == StMul) begin
                p_q   <= p_next;
                cnt_q <= cnt_q + 1'b1;
                if (mul_last) begin
                    result <= p_next[2*WIDTH-1:0];
                    ovf    <= |p_next[2*WIDTH-1:WIDTH];
                    carry  <= 1'b0;
                end
            end
        end
    end

    assign busy = (state_q == StExec) || (state_q == StMul);
    assign done = (state_q == StDone);

`ifdef ALU_SEQ_STICKY_OVF_EN
    logic sticky_q;

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= (done & ovf) | (sticky_q & ~ovf_clr);
        end
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_adder_sequencer.sv
// Self-checking bench: arithmetic reference model compared every cycle plus literal vectors.
module tb_alu_adder_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [5:0]  a, b;
    logic        busy, done, ovf, carry;
    logic [11:0] result;
`ifdef ALU_SEQ_STICKY_OVF_EN
    logic        ovf_clr;
    logic        ovf_sticky;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_adder_sequencer #(.WIDTH(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .carry  (carry)
`ifdef ALU_SEQ_STICKY_OVF_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on 6-bit unsigned encodings.
    function automatic int sx(input int v);
        return (v >= 32) ? v - 64 : v;
    endfunction

    function automatic int f_res(input int o, input int x, input int y);
        case (o)
            0:       return (x + y) % 64;
            1:       return (x - y + 64) % 64;
            2:       return (64 - y) % 64;
            default: return x * y;
        endcase
    endfunction

    function automatic logic f_ovf(input int o, input int x, input int y);
        int s;
        case (o)
            0:       s = sx(x) + sx(y);
            1:       s = sx(x) - sx(y);
            2:       s = -sx(y);
            default: return (x * y) > 63;
        endcase
        return (s > 31) || (s < -32);
    endfunction

    function automatic logic f_carry(input int o, input int x, input int y);
        case (o)
            0:       return (x + y) > 63;
            1:       return x >= y;
            2:       return y == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Model: busy_left counts remaining busy cycles; done is shown the cycle after it hits zero.
    int          busy_left;
    logic        m_done, m_ovf, m_carry, p_ovf, p_carry;
    logic [11:0] m_res, p_res;
`ifdef ALU_SEQ_STICKY_OVF_EN
    logic        m_sticky;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left <= 0;
            m_done    <= 1'b0;
            m_res     <= '0;
            m_ovf     <= 1'b0;
            m_carry   <= 1'b0;
            p_res     <= '0;
            p_ovf     <= 1'b0;
            p_carry   <= 1'b0;
`ifdef ALU_SEQ_STICKY_OVF_EN
            m_sticky  <= 1'b0;
`endif
        end else begin
            m_done <= 1'b0;
`ifdef ALU_SEQ_STICKY_OVF_EN
            m_sticky <= (m_done & m_ovf) | (m_sticky & ~ovf_clr);
`endif
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    m_done  <= 1'b1;
                    m_res   <= p_res;
                    m_ovf   <= p_ovf;
                    m_carry <= p_carry;
                end
            end else if (start) begin
                busy_left <= (op == 2'b11) ? 6 : 1;
                p_res     <= 12'(f_res(int'(op), int'(a), int'(b)));
                p_ovf     <= f_ovf(int'(op), int'(a), int'(b));
                p_carry   <= f_carry(int'(op), int'(a), int'(b));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", 32'(busy), 32'(busy_left != 0));
            check("done", 32'(done), 32'(m_done));
            check("result", 32'(result), 32'(m_res));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("carry", 32'(carry), 32'(m_carry));
`ifdef ALU_SEQ_STICKY_OVF_EN
            check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
`endif
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [5:0] x, input logic [5:0] y);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns with the time at the negedge of the done cycle; n = busy cycles observed first.
    task automatic wait_done(input string name, output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic expect_out(input string name, input logic [11:0] r, input logic o,
                              input logic c);
        check({name, "_result"}, 32'(result), 32'(r));
        check({name, "_ovf"}, 32'(ovf), 32'(o));
        check({name, "_carry"}, 32'(carry), 32'(c));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
`ifdef ALU_SEQ_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        expect_out("rst", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(2'b00, 6'd20, 6'd15);
        wait_done("add", n);
        check("add_latency", 32'(n), 32'd1);
        expect_out("add", 12'h023, 1'b1, 1'b0);
        check("model_add", 32'(m_res), 32'h023);

        start_op(2'b01, 6'd5, 6'd9);
        wait_done("sub1", n);
        expect_out("sub1", 12'h03C, 1'b0, 1'b0);
        start_op(2'b01, 6'd9, 6'd5);
        wait_done("sub2", n);
        expect_out("sub2", 12'h004, 1'b0, 1'b1);

        start_op(2'b10, 6'd0, 6'b100000);
        wait_done("neg1", n);
        expect_out("neg1", 12'h020, 1'b1, 1'b0);
        start_op(2'b10, 6'd0, 6'd1);
        wait_done("neg2", n);
        expect_out("neg2", 12'h03F, 1'b0, 1'b0);
        check("model_neg2", 32'(m_res), 32'h03F);

        start_op(2'b11, 6'd63, 6'd63);
        wait_done("mul1", n);
        check("mul_latency", 32'(n), 32'd6);
        expect_out("mul1", 12'hF81, 1'b1, 1'b0);
        check("model_mul1", 32'(m_res), 32'hF81);

        // Back-to-back: start presented during DONE.
        start = 1'b1;
        op    = 2'b11;
        a     = 6'd7;
        b     = 6'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("mul2", n);
        check("b2b_latency", 32'(n), 32'd6);
        expect_out("mul2", 12'h023, 1'b0, 1'b0);

        start_op(2'b11, 6'd0, 6'd45);
        wait_done("mul_a0", n);
        expect_out("mul_a0", 12'h000, 1'b0, 1'b0);
        start_op(2'b11, 6'd37, 6'd0);
        wait_done("mul_b0", n);
        expect_out("mul_b0", 12'h000, 1'b0, 1'b0);

        // Start during MUL in cycle 3 is ignored.
        start_op(2'b11, 6'd7, 6'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        a     = 6'd1;
        b     = 6'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("mul_ign", n);
        check("mul_ign_latency", 32'(n), 32'd3);
        expect_out("mul_ign", 12'h023, 1'b0, 1'b0);

        // Reset in cycle 4 of a MUL aborts it with no done.
        start_op(2'b11, 6'd63, 6'd63);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        expect_out("abort", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        check("abort_result", 32'(result), 32'h000);

`ifdef ALU_SEQ_STICKY_OVF_EN
        start_op(2'b00, 6'd20, 6'd15);
        wait_done("st_add1", n);
        check("st_pre", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        check("st_set", 32'(ovf_sticky), 32'd1);
        start_op(2'b00, 6'd1, 6'd1);
        wait_done("st_add2", n);
        @(negedge clk);
        check("st_hold", 32'(ovf_sticky), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("st_clr", 32'(ovf_sticky), 32'd0);
        start_op(2'b00, 6'd20, 6'd15);
        wait_done("st_add3", n);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("st_set_wins", 32'(ovf_sticky), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
